// File: rtl/candy_sram_arbiter.sv
// Round-robin two-port sequencer for an external async SRAM: grant at the IDLE edge, WAIT_CYCLES of strobe,
// then one DONE cycle with ack (WAIT_CYCLES+2 cycles per access); a losing or late requester simply holds req.
module candy_sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 24,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              sel;
    logic              sel_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        drive_d    = drive_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        // On conflict the port that did not win last time goes next.
        sel        = (m0_req_i && m1_req_i) ? ~last_gnt_q : m1_req_i;
        sel_we     = sel ? m1_we_i : m0_we_i;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_d    = ACCESS;
                    cnt_d      = CNT_INIT;
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    we_d       = sel_we;
                    addr_d     = sel ? m1_addr_i : m0_addr_i;
                    wdata_d    = sel ? m1_wdata_i : m0_wdata_i;
                    ce_n_d     = 1'b0;
                    oe_n_d     = sel_we;
                    we_n_d     = ~sel_we;
                    drive_d    = sel_we;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    if (!we_q) begin
                        if (gnt_q) rdata1_d = sram_data_io;
                        else       rdata0_d = sram_data_io;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Write data was held through DONE; release the bus now.
                state_d = IDLE;
                drive_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            drive_q    <= drive_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign sram_data_io = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign m0_ack_o     = ack0_q;
    assign m1_ack_o     = ack1_q;
    assign m0_rdata_o   = rdata0_q;
    assign m1_rdata_o   = rdata1_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/candy_sram_arbiter.md
# candy_sram_arbiter

Two-port arbiter and access sequencer for the external asynchronous SRAM. It shares the single SRAM bus between a data port (m0, memory stage) and an instruction-fetch port (m1), with round-robin arbitration on conflict. It drives the active-low chip, output and write enables with a programmable access length. It owns the tristate data bus, registers read data and returns a one-cycle acknowledge per completed transaction.

## Interface
- `ADDR_W`, default 20: SRAM word address width.
- `DATA_W`, default 24: SRAM data width.
- `WAIT_CYCLES`, default 2: cycles the strobe (OE_n or WE_n) is held low per access; legal range 1..15.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `m0_req_i` in 1: port 0 request; held with `m0_we_i`/`m0_addr_i`/`m0_wdata_i` stable until ack.
- `m0_we_i` in 1: 1 = write, 0 = read.
- `m0_addr_i` in ADDR_W: word address.
- `m0_wdata_i` in DATA_W: write data.
- `m0_ack_o` out 1: one-cycle completion pulse.
- `m0_rdata_o` out DATA_W: read data; valid in ack cycle, held until next port-0 read completes.
- `m1_req_i`, `m1_we_i`, `m1_addr_i`, `m1_wdata_i`, `m1_ack_o`, `m1_rdata_o`: same as port 0, for port 1.
- `sram_addr_o` out ADDR_W: SRAM address, registered.
- `sram_data_io` inout DATA_W: SRAM data bus; high-Z unless writing.
- `sram_ce_n_o` out 1: chip enable, active-low.
- `sram_oe_n_o` out 1: output enable, active-low.
- `sram_we_n_o` out 1: write enable, active-low.
- `busy_o` out 1: high whenever state != IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: arbitrate on sampled reqs.
  - Only one req high: grant that port.
  - Both high: grant the port opposite `last_gnt`.
  - On grant: latch port id, we, addr and wdata; set `last_gnt`; load counter with WAIT_CYCLES-1; go ACCESS.
  - No req: stay in IDLE.
- ACCESS: `ce_n`=0.
  - Read: `oe_n`=0, `we_n`=1, bus high-Z.
  - Write: `we_n`=0, `oe_n`=1, bus driven with latched wdata.
  - Counter decrements each cycle. On the counter==0 edge, a read captures `sram_data_io` into the granted port's rdata register. Then go DONE.
- DONE: `ce_n`=`oe_n`=`we_n`=1.
  - Write: bus still driven (data hold); read: bus high-Z.
  - Granted port's ack=1. Go IDLE.
- The ungranted port's ack and rdata are never affected.
- Requests arriving mid-transaction wait; they are sampled in the next IDLE.
- `sram_addr_o` is loaded on grant and holds its value through IDLE.
- `ce_n`/`oe_n`/`we_n` are registered outputs; no combinational path from req to SRAM pins.
- `oe_n` and `we_n` are never both low. The bus is never driven while `oe_n`=0.

## Timing
- Reset values:
  - `ce_n`/`oe_n`/`we_n`=1; bus high-Z.
  - `m0_ack_o`=`m1_ack_o`=0; `m0_rdata_o`=`m1_rdata_o`=0; `sram_addr_o`=0; `busy_o`=0.
  - state IDLE; `last_gnt`=1, so port 0 wins the first conflict.
- Latency, with req sampled high in IDLE cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - DONE and ack fall in cycle WAIT_CYCLES+1.
  - IDLE falls in cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+2 cycles; IDLE always costs one turnaround cycle.
- Requester may change or drop req in the cycle after ack. If req is still high in IDLE, it is treated as a new transaction.
- Back-to-back conflict: ports alternate strictly while both hold req.
- rst asserted in any state:
  - Next cycle is IDLE with reset values.
  - The aborted transaction gets no ack, and its rdata is not updated.
- Counter width is 4 bits. WAIT_CYCLES=1 gives a single ACCESS cycle.

## Test plan
- Single read, WAIT_CYCLES=2: m0 reads addr 0x00010; SRAM model returns 0xABCDEF.
  - Required: `ce_n`/`oe_n` low in cycles 1–2.
  - Required: `m0_ack_o`=1 in cycle 3 only; `m0_rdata_o`=0xABCDEF from cycle 3 on.
  - Required: `m1_ack_o` stays 0.
- Single write: m1 writes 0x123456 to 0x00FFF.
  - Required: `we_n` low in cycles 1–2, bus=0x123456 in cycles 1–3.
  - Required: bus high-Z in cycle 4; `m1_ack_o` pulse in cycle 3.
  - Required: the model holds 0x123456 at 0x00FFF.
- Simultaneous reqs from reset, both held for 4 transactions.
  - Required: grant order m0, m1, m0, m1; each ack 4 cycles apart; `busy_o` low exactly one cycle between.
- Write then read same address on m0: write 0x000055, then read.
  - Required: read returns 0x000055.
  - Required: no cycle with `oe_n`=0 while the bus is driven.
- Reset mid-ACCESS: assert rst in cycle 1 of an m0 read.
  - Required: next cycle all enables high, bus high-Z, no ack, `m0_rdata_o` unchanged.
  - Required: a fresh request afterwards completes normally.
- WAIT_CYCLES=1: m0 issues continuous reads.
  - Required: ack every 3 cycles; `oe_n` low exactly 1 cycle per access.
